// File: rtl/rank_pipe_reader_if.sv
// rank_pipe_reader_if: rank pipe pop side, PIFO insert/dequeue side and status counters
interface rank_pipe_reader_if #(
    parameter int RANK_WIDTH     = 16,
    parameter int RANK_OUT_WIDTH = 12,
    parameter int META_WIDTH     = 16
);
    logic                      rank_valid_in;
    logic [RANK_WIDTH-1:0]     rank_in;
    logic [META_WIDTH-1:0]     meta_in;
    logic                      rank_remove;
    logic                      pifo_busy;
    logic                      pifo_insert;
    logic [RANK_OUT_WIDTH-1:0] pifo_rank_out;
    logic [META_WIDTH-1:0]     pifo_meta_out;
    logic                      deq_valid;
    logic [RANK_WIDTH-1:0]     deq_rank;
    logic [31:0]               fwd_count;
    logic [15:0]               sat_count;
    modport master (
        output rank_valid_in, rank_in, meta_in, pifo_busy, deq_valid, deq_rank,
        input  rank_remove, pifo_insert, pifo_rank_out, pifo_meta_out, fwd_count, sat_count
    );
    modport slave (
        input  rank_valid_in, rank_in, meta_in, pifo_busy, deq_valid, deq_rank,
        output rank_remove, pifo_insert, pifo_rank_out, pifo_meta_out, fwd_count, sat_count
    );
endinterface

// File: rtl/rank_pipe_reader.sv
// rank_pipe_reader: pops the rank pipe, re-bases ranks against PIFO head and feeds the PIFO via a 2-entry skid buffer
module rank_pipe_reader #(
    parameter int RANK_WIDTH     = 16,
    parameter int RANK_OUT_WIDTH = 12,
    parameter int META_WIDTH     = 16
) (
    input logic               clk,
    input logic               rst,
    rank_pipe_reader_if.slave io
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    localparam logic [RANK_WIDTH-1:0] REL_MAX = RANK_WIDTH'((64'd1 << RANK_OUT_WIDTH) - 64'd1);
    localparam logic [RANK_WIDTH-1:0] HALF    = RANK_WIDTH'(64'd1 << (RANK_WIDTH - 1));
    state_t                    state_q, state_d;
    logic [RANK_OUT_WIDTH-1:0] rel0_q, rel0_d, rel1_q, rel1_d, rel_new;
    logic [META_WIDTH-1:0]     meta0_q, meta0_d, meta1_q, meta1_d;
    logic [RANK_WIDTH-1:0]     base_q, base_d, diff;
    logic [31:0]               fwd_q;
    logic [15:0]               sat_q;
    logic                      pop, drain, behind, sat;
    // modular distance from base; upper half of the ring means the rank is behind base
    assign diff    = io.rank_in - base_q;
    assign behind  = diff >= HALF;
    assign sat     = !behind && diff > REL_MAX;
    assign rel_new = behind ? '0 : sat ? '1 : diff[RANK_OUT_WIDTH-1:0];
    assign pop     = io.rank_valid_in && !rst && state_q != FULL;
    assign drain   = state_q != EMPTY && !io.pifo_busy && !rst;
    assign base_d  = io.deq_valid && (io.deq_rank - base_q) < HALF ? io.deq_rank : base_q;
    assign io.rank_remove   = pop;
    assign io.pifo_insert   = drain;
    assign io.pifo_rank_out = state_q == EMPTY ? '0 : rel0_q;
    assign io.pifo_meta_out = state_q == EMPTY ? '0 : meta0_q;
    assign io.fwd_count     = fwd_q;
    assign io.sat_count     = sat_q;
    always_comb begin
        state_d = state_q;
        rel0_d  = rel0_q;
        meta0_d = meta0_q;
        rel1_d  = rel1_q;
        meta1_d = meta1_q;
        case (state_q)
            EMPTY: begin
                state_d = pop ? ONE : EMPTY;
                rel0_d  = pop ? rel_new : rel0_q;
                meta0_d = pop ? io.meta_in : meta0_q;
            end
            ONE: begin
                state_d = pop && !drain ? FULL : !pop && drain ? EMPTY : ONE;
                rel0_d  = pop && drain ? rel_new : rel0_q;
                meta0_d = pop && drain ? io.meta_in : meta0_q;
                rel1_d  = pop && !drain ? rel_new : rel1_q;
                meta1_d = pop && !drain ? io.meta_in : meta1_q;
            end
            FULL: begin
                state_d = drain ? ONE : FULL;
                rel0_d  = drain ? rel1_q : rel0_q;
                meta0_d = drain ? meta1_q : meta0_q;
            end
            default: state_d = EMPTY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rel0_q  <= '0;
            meta0_q <= '0;
            rel1_q  <= '0;
            meta1_q <= '0;
            base_q  <= '0;
            fwd_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            rel0_q  <= rel0_d;
            meta0_q <= meta0_d;
            rel1_q  <= rel1_d;
            meta1_q <= meta1_d;
            base_q  <= base_d;
            fwd_q   <= fwd_q + 32'(drain);
            sat_q   <= sat_q + 16'(pop && sat);
        end
    end
endmodule

// File: tb/tb_rank_pipe_reader.sv
// tb_rank_pipe_reader: queue-based reference model with per-cycle compare plus directed literal checks
module tb_rank_pipe_reader;
    typedef struct packed {logic [15:0] r; logic [15:0] m;} src_t;
    typedef struct packed {logic [11:0] r; logic [15:0] m;} buf_t;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    rank_pipe_reader_if io ();
    rank_pipe_reader dut (.clk(clk), .rst(rst), .io(io));
    src_t src[$];
    buf_t mq[$];
    buf_t dlv[$];
    int unsigned m_base, m_fwd, m_sat;
    bit armed;
    int npass, ntot;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    function automatic logic [11:0] rebase(input int unsigned r, input int unsigned b, output bit s);
        int unsigned d;
        d = (r - b) & 32'hFFFF;
        s = 0;
        if (d >= 32768) return 12'h0;
        if (d > 4095) begin
            s = 1;
            return 12'hFFF;
        end
        return d[11:0];
    endfunction
    always @(posedge clk) begin : model
        bit ins, rem, s;
        logic [11:0] rel;
        if (rst) begin
            mq.delete();
            m_base = 0;
            m_fwd = 0;
            m_sat = 0;
            armed = 1;
        end else begin
            ins = mq.size() > 0 && !io.pifo_busy;
            rem = io.rank_valid_in && mq.size() < 2;
            if (io.pifo_insert) dlv.push_back({io.pifo_rank_out, io.pifo_meta_out});
            if (ins) begin
                void'(mq.pop_front());
                m_fwd++;
            end
            if (rem) begin
                rel = rebase(io.rank_in, m_base, s);
                m_sat += s;
                mq.push_back({rel, io.meta_in});
                if (src.size() > 0) void'(src.pop_front());
            end
            if (io.deq_valid && ((io.deq_rank - m_base) & 32'hFFFF) < 32768) m_base = io.deq_rank;
        end
    end
    always @(negedge clk) begin : compare
        bit er, ei;
        buf_t h;
        if (armed) begin
            er = !rst && io.rank_valid_in && mq.size() < 2;
            ei = !rst && mq.size() > 0 && !io.pifo_busy;
            h = mq.size() > 0 ? mq[0] : '0;
            chk("rank_remove", io.rank_remove, er);
            chk("pifo_insert", io.pifo_insert, ei);
            chk("pifo_rank_out", io.pifo_rank_out, h.r);
            chk("pifo_meta_out", io.pifo_meta_out, h.m);
            chk("fwd_count", io.fwd_count, m_fwd);
            chk("sat_count", io.sat_count, m_sat & 32'hFFFF);
        end
    end
    task automatic drive();
        io.rank_valid_in = src.size() > 0;
        io.rank_in = src.size() > 0 ? src[0].r : '0;
        io.meta_in = src.size() > 0 ? src[0].m : '0;
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask
    task automatic deq(input logic [15:0] r);
        io.deq_valid = 1;
        io.deq_rank = r;
        tick(1);
        io.deq_valid = 0;
    endtask
    initial begin
        io.pifo_busy = 0;
        io.deq_valid = 0;
        io.deq_rank = 0;
        drive();
        tick(2);
        rst = 0;
        // in-order delivery with one-cycle latency
        dlv.delete();
        src.push_back({16'd5, 16'hA});
        src.push_back({16'd6, 16'hB});
        src.push_back({16'd7, 16'hC});
        drive();
        tick(6);
        chk("t1_fwd", io.fwd_count, 3);
        chk("t1_n", dlv.size(), 3);
        for (int i = 0; i < 3 && i < dlv.size(); i++) begin
            chk("t1_rank", dlv[i].r, 5 + i);
            chk("t1_meta", dlv[i].m, 10 + i);
        end
        // backpressure: only two entries accepted while busy
        io.pifo_busy = 1;
        dlv.delete();
        for (int i = 0; i < 4; i++) src.push_back({16'(10 + i), 16'(16'h100 + i)});
        drive();
        tick(5);
        chk("t2_src_left", src.size(), 2);
        chk("t2_remove", io.rank_remove, 0);
        chk("t2_head", io.pifo_rank_out, 10);
        io.pifo_busy = 0;
        tick(8);
        chk("t2_n", dlv.size(), 4);
        for (int i = 0; i < 4 && i < dlv.size(); i++) chk("t2_rank", dlv[i].r, 10 + i);
        // re-basing against dequeued head; base never moves back
        deq(16'd100);
        chk("t3_base", m_base, 100);
        dlv.delete();
        src.push_back({16'd103, 16'h3});
        src.push_back({16'd99, 16'h4});
        drive();
        tick(5);
        chk("t3_n", dlv.size(), 2);
        if (dlv.size() == 2) begin
            chk("t3_r0", dlv[0].r, 3);
            chk("t3_r1", dlv[1].r, 0);
        end
        deq(16'd90);
        chk("t3_base_hold", m_base, 100);
        src.push_back({16'd105, 16'h5});
        drive();
        tick(4);
        chk("t3_r2", dlv.size() > 0 ? dlv[dlv.size()-1].r : 12'hx, 5);
        // saturation
        rst = 1;
        tick(1);
        rst = 0;
        dlv.delete();
        src.push_back({16'd5000, 16'h7});
        drive();
        tick(4);
        chk("t4_rank", dlv.size() > 0 ? dlv[0].r : 12'hx, 4095);
        chk("t4_sat", io.sat_count, 1);
        // wrap across 0xFFFF
        deq(16'h7000);
        deq(16'hE000);
        deq(16'hFFF0);
        chk("t5_base", m_base, 16'hFFF0);
        dlv.delete();
        src.push_back({16'h0005, 16'h9});
        drive();
        tick(4);
        chk("t5_rank", dlv.size() > 0 ? dlv[0].r : 12'hx, 12'h15);
        // reset while full and stalled
        io.pifo_busy = 1;
        for (int i = 1; i <= 3; i++) src.push_back({16'(16'hFFF0 + i), 16'(i)});
        drive();
        tick(4);
        chk("t6_full", mq.size(), 2);
        rst = 1;
        src.delete();
        drive();
        tick(1);
        rst = 0;
        io.pifo_busy = 0;
        dlv.delete();
        #1;
        chk("t6_insert", io.pifo_insert, 0);
        chk("t6_fwd", io.fwd_count, 0);
        chk("t6_sat", io.sat_count, 0);
        src.push_back({16'd42, 16'h42});
        drive();
        tick(3);
        chk("t6_n", dlv.size(), 1);
        chk("t6_rank", dlv.size() > 0 ? dlv[0].r : 12'hx, 42);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (src.size() < 4 && $urandom_range(0, 3) != 0)
                src.push_back({($urandom_range(0, 9) == 0) ? 16'($urandom) :
                               16'(m_base + $urandom_range(0, 5000) - 200), 16'($urandom)});
            io.pifo_busy = $urandom_range(0, 9) < 3;
            io.deq_valid = $urandom_range(0, 7) == 0;
            io.deq_rank = 16'(m_base + $urandom_range(0, 300) - 50);
            rst = $urandom_range(0, 399) == 0;
            drive();
            tick(1);
        end
        rst = 0;
        io.deq_valid = 0;
        io.pifo_busy = 0;
        tick(10);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/rank_pipe_reader.md
Name: rank_pipe_reader

Overview:
- Reader end of the rank-pipe output interface, a fall-through FIFO exposing valid, rank and meta, popped by a remove strobe.
- Pops rank/meta pairs from a rank block as space allows and re-bases each absolute rank against the PIFO's current head rank.
- Presents the re-based rank to the PIFO insert port through a 2-entry registered skid buffer, honouring PIFO busy backpressure.
- Sits between each rank pipe and its PIFO; also keeps forwarded and saturated counts for status.

Parameters:
RANK_WIDTH, 16, width of absolute rank from the rank pipe and of PIFO dequeue rank
RANK_OUT_WIDTH, 12, width of re-based rank sent to the PIFO; must be <= RANK_WIDTH-1
META_WIDTH, 16, metadata width carried unchanged

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rank_valid_in  in  1  rank pipe has a head entry (rank pipe valid_out)
rank_in  in  RANK_WIDTH  head absolute rank (fall-through, valid when rank_valid_in=1)
meta_in  in  META_WIDTH  head metadata
rank_remove  out  1  pop strobe to rank pipe; combinational
pifo_busy  in  1  PIFO cannot accept an insert this cycle
pifo_insert  out  1  insert strobe to PIFO
pifo_rank_out  out  RANK_OUT_WIDTH  re-based rank
pifo_meta_out  out  META_WIDTH  metadata
deq_valid  in  1  PIFO dequeued an entry this cycle
deq_rank  in  RANK_WIDTH  absolute rank of dequeued entry
fwd_count  out  32  inserts issued to PIFO, wraps
sat_count  out  16  ranks clamped high, wraps

Behaviour:
- Reset (sync, rst=1 at posedge) clears all state:
  - buffer count=0; base_rank=0; fwd_count=0; sat_count=0.
  - pifo_insert=0 and rank_remove=0 while rst=1; pifo_rank_out/pifo_meta_out=0 while the buffer is empty.
  - A reset mid-transfer discards buffered entries; no insert is issued for them.
- Buffer: 2-entry FIFO of {rel_rank, meta}; states EMPTY(0), ONE(1), FULL(2).
- Drain:
  - pifo_insert = (count>0) && !pifo_busy; head is presented on pifo_rank_out/pifo_meta_out.
  - Head is consumed in the same cycle pifo_insert=1.
  - pifo_rank_out/meta_out hold stable while pifo_busy=1.
- Pop:
  - rank_remove = rank_valid_in && !rst && (count<2). Popping depends only on registered count, never on same-cycle drain.
  - A popped entry is written into the buffer at the next posedge.
  - Latency: rank_in popped in cycle N appears on pifo_insert in cycle N+1 at earliest.
- Transitions (pop p, drain d):
  - EMPTY: p -> ONE; otherwise stay.
  - ONE: p&d -> ONE; p&!d -> FULL; !p&d -> EMPTY; otherwise stay.
  - FULL: d -> ONE, no pop possible; otherwise stay.
- Throughput: sustained 1 entry/cycle in ONE with pifo_busy=0.
- Order is strictly FIFO.
- Re-basing is computed at pop time:
  - diff = (rank_in - base_rank) mod 2^RANK_WIDTH.
  - diff MSB=1 (rank behind base): rel_rank=0, no count.
  - else if diff > 2^RANK_OUT_WIDTH-1: rel_rank = all ones, sat_count+1.
  - else rel_rank = diff[RANK_OUT_WIDTH-1:0].
  - Uses registered base_rank; a same-cycle deq_valid affects only later pops.
- Base update: on deq_valid, if (deq_rank - base_rank) mod 2^RANK_WIDTH has MSB=0, base_rank <= deq_rank; otherwise ignore (base never moves backward). Wrap of absolute rank is handled by the modular compare.
- Already-buffered entries keep their rel_rank when base_rank changes.
- Counters:
  - fwd_count increments on each pifo_insert.
  - sat_count increments once per clamped pop.
  - Both wrap silently.
- rank_in/meta_in are ignored when rank_valid_in=0.

Test Plan:
- Reset, then rank_valid_in=1 with ranks 5,6,7, meta A,B,C, pifo_busy=0 -> rank_remove high 3 cycles; pifo_insert first asserts 1 cycle after first pop; rel ranks 5,6,7 with meta A,B,C; fwd_count=3.
- Hold pifo_busy=1 with 4 entries pending -> exactly 2 pops then rank_remove=0, head stable; release busy -> all 4 delivered in order, no loss or duplication.
- deq_valid with deq_rank=100, then pop ranks 103 and 99 -> rel ranks 3 and 0; then deq_rank=90 -> base stays 100.
- base=0, pop rank 5000 with RANK_OUT_WIDTH=12 -> pifo_rank_out=4095, sat_count=1.
- base=0xFFF0, pop rank 0x0005 -> rel rank 0x15 (wrap handled).
- Assert rst while FULL with pifo_busy=1 -> next cycle pifo_insert=0, count 0, counters 0; the first post-reset pop is delivered normally.
